// File: rtl/y86_pkg.sv
// Shared Y86-64 field widths and encodings used by the pipeline stage registers.
package y86_pkg;

    localparam int unsigned STAT_W  = 3;
    localparam int unsigned ICODE_W = 4;
    localparam int unsigned REG_W   = 4;

    localparam logic [STAT_W-1:0] AOK = 3'h1;
    localparam logic [STAT_W-1:0] HLT = 3'h2;
    localparam logic [STAT_W-1:0] ADR = 3'h3;
    localparam logic [STAT_W-1:0] INS = 3'h4;

    localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
    localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
    localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

    localparam logic [REG_W-1:0] RNONE = 4'hF;

    // Non-value stage fields, kept together so hold/load/bubble treat them as one unit.
    typedef struct packed {
        logic [STAT_W-1:0]  status;
        logic [ICODE_W-1:0] icode;
        logic [3:0]         ifun;
        logic [REG_W-1:0]   rA;
        logic [REG_W-1:0]   rB;
        logic               Cnd;
    } stage_ctl_t;

    function automatic stage_ctl_t bubble_ctl();
        stage_ctl_t c;
        c.status = AOK;
        c.icode  = I_NOP;
        c.ifun   = 4'h0;
        c.rA     = RNONE;
        c.rB     = RNONE;
        c.Cnd    = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/y86_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all-ones.
module y86_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (RST) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/y86_pipe_reg.sv
// Y86-64 pipeline stage register with stall, bubble injection and a sticky conflict flag.
// Define PIPE_REG_PERF_EN to add stall/bubble/load saturating performance counters.
module y86_pipe_reg
    import y86_pkg::*;
#(
    parameter int unsigned W     = 64,
    parameter int unsigned NVAL  = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                stall,
    input  logic                bubble,
    input  logic [STAT_W-1:0]   in_status,
    input  logic [ICODE_W-1:0]  in_icode,
    input  logic [3:0]          in_ifun,
    input  logic [REG_W-1:0]    in_rA,
    input  logic [REG_W-1:0]    in_rB,
    input  logic [NVAL*W-1:0]   in_val,
    input  logic                in_Cnd,
    output logic [STAT_W-1:0]   out_status,
    output logic [ICODE_W-1:0]  out_icode,
    output logic [3:0]          out_ifun,
    output logic [REG_W-1:0]    out_rA,
    output logic [REG_W-1:0]    out_rB,
    output logic [NVAL*W-1:0]   out_val,
    output logic                out_Cnd,
    output logic                out_is_bubble,
    output logic                ctl_err
`ifdef PIPE_REG_PERF_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt,
    output logic [CNT_W-1:0]    load_cnt
`endif
);

    stage_ctl_t        ctl_q, ctl_d, ctl_in;
    logic [NVAL*W-1:0] val_q, val_d;
    logic              bub_q, bub_d;
    logic              err_q, err_d;

    assign ctl_in = '{status: in_status, icode: in_icode, ifun: in_ifun,
                      rA: in_rA, rB: in_rB, Cnd: in_Cnd};

    // Priority RST > stall > bubble > load; stall+bubble together is a hold plus error.
    always_comb begin
        ctl_d = ctl_q;
        val_d = val_q;
        bub_d = bub_q;
        err_d = err_q;
        if (RST) begin
            ctl_d = bubble_ctl();
            val_d = '0;
            bub_d = 1'b1;
            err_d = 1'b0;
        end else if (stall) begin
            if (bubble) begin
                err_d = 1'b1;
            end
        end else if (bubble) begin
            ctl_d = bubble_ctl();
            val_d = '0;
            bub_d = 1'b1;
        end else begin
            ctl_d = ctl_in;
            val_d = in_val;
            bub_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        ctl_q <= ctl_d;
        val_q <= val_d;
        bub_q <= bub_d;
        err_q <= err_d;
    end

    assign out_status    = ctl_q.status;
    assign out_icode     = ctl_q.icode;
    assign out_ifun      = ctl_q.ifun;
    assign out_rA        = ctl_q.rA;
    assign out_rB        = ctl_q.rB;
    assign out_Cnd       = ctl_q.Cnd;
    assign out_val       = val_q;
    assign out_is_bubble = bub_q;
    assign ctl_err       = err_q;

`ifdef PIPE_REG_PERF_EN
    logic stall_inc, bubble_inc, load_inc;

    assign stall_inc  = stall;
    assign bubble_inc = !stall && bubble;
    assign load_inc   = !stall && !bubble;

    y86_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    y86_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (bubble_inc),
        .cnt (bubble_cnt)
    );

    y86_sat_counter #(.CNT_W(CNT_W)) u_load_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (load_inc),
        .cnt (load_cnt)
    );
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: doc/y86_pipe_reg.md
# y86_pipe_reg

Parametrised Y86-64 pipeline stage register: the generic successor to the fixed per-stage latches between fetch/decode/execute/memory/writeback. It captures one instruction's worth of stage state each cycle. It adds synchronous reset, stall (hold), bubble (inject NOP), a bubble-tag output, a control-conflict flag and optional performance counters. One instance per stage boundary; the hazard/control unit drives stall and bubble.

## Interface

Parameters:
- W, 64: width of each value lane.
- NVAL, 5: number of value lanes (e.g. valC, valP, valA, valB, valE).
- CNT_W, 32: performance counter width.

Ports:
- CLK input 1: clock, all state updates on rising edge.
- RST input 1: synchronous, active-high reset.
- stall input 1: hold current contents.
- bubble input 1: load NOP bubble instead of inputs.
- in_status input 3: stage status code.
- in_icode input 4: instruction code.
- in_ifun input 4: function code.
- in_rA input 4: register A id.
- in_rB input 4: register B id.
- in_val input NVAL*W: value lanes; lane k occupies bits [k*W +: W].
- in_Cnd input 1: condition result.
- out_status, out_icode, out_ifun, out_rA, out_rB, out_val, out_Cnd output (same widths): registered copies.
- out_is_bubble output 1: 1 when the register holds an injected bubble.
- ctl_err output 1: sticky; set when stall and bubble are both asserted in one cycle.
- stall_cnt, bubble_cnt, load_cnt output CNT_W each: present only with PIPE_REG_PERF_EN.

## Operation

- Bubble image: status=AOK (3'h1), icode=NOP (4'h1), ifun=0, rA=rB=RNONE (4'hF), all val lanes 0, Cnd=0, out_is_bubble=1.
- Per-cycle priority is RST > stall > bubble > load.
- RST: load the bubble image. Clear ctl_err. Clear counters.
- stall=1: all outputs hold. stall_cnt increments.
- bubble=1 (stall=0): load the bubble image. bubble_cnt increments.
- Neither asserted: load all in_* fields. out_is_bubble=0. load_cnt increments.
- stall=1 and bubble=1: treated as stall (hold). ctl_err is set and stays at 1 until RST.
- Counters saturate at all-ones and do not wrap.
- Fields are copied verbatim. No decoding of icode or status is done beyond the bubble image.
- Lanes are independent. NVAL=1 is legal.

## Timing

- Latency is 1 cycle: inputs sampled at edge N appear at the outputs after edge N, stable through edge N+1.
- No combinational path from any input to any output.
- Reset values of every output are the bubble image, with ctl_err=0 and counters 0.
- RST asserted mid-stall overrides the stall. The bubble image appears after that edge.
- Release from stall: the first cycle with stall=0 loads the current inputs (or the bubble image if bubble=1). There is no replay of the inputs seen during the stall.
- Counter update timing: counters update on the same edge as the action they count, so the count is visible one cycle later.

## Configuration

- PIPE_REG_PERF_EN defined: stall_cnt, bubble_cnt and load_cnt ports and their logic exist, with behaviour as described above.
- PIPE_REG_PERF_EN undefined: the counter ports and logic are absent. All other behaviour is bit-identical.

## Structure

- Shared package y86_pkg holds:
  - status codes: AOK=1, HLT=2, ADR=3, INS=4;
  - icode constants, including NOP=4'h1;
  - RNONE=4'hF;
  - the widths of the status, icode and register-id fields.
- Sub-module y86_sat_counter: a saturating counter (CNT_W, RST, inc), instantiated three times under PIPE_REG_PERF_EN.

## Test plan

- Reset: hold RST=1 for 2 cycles with arbitrary inputs. Outputs must be icode=1, rA=rB=F, status=1, val=0, out_is_bubble=1, ctl_err=0, counters 0.
- Load: icode=6, rA=2, rB=3, lane0=0x1234, Cnd=1, stall=bubble=0. The next cycle the outputs equal the inputs, out_is_bubble=0 and load_cnt=1.
- Stall: load icode=3, then stall for 3 cycles while the inputs change to icode=7. Outputs must hold icode=3 and stall_cnt=3. On release the outputs take icode=7.
- Bubble: with the register holding icode=5, pulse bubble for 1 cycle. Expect the NOP image, out_is_bubble=1 and bubble_cnt=1. The next normal cycle loads normally.
- Conflict and reset priority: assert stall=bubble=1. Outputs must hold and ctl_err=1 (sticky across later cycles). Then assert RST while stall=1. Expect the bubble image and ctl_err=0.
- Saturation: CNT_W=4, stall held for 20 cycles. stall_cnt must stop at 15.
